// File: rtl/mac_pkg.sv
// mac_pkg: shared defaults for the multiply-accumulate datapath.
//   MAC_N      - default operand width
//   MAC_G      - default accumulator guard bits
//   MAC_CNT_W  - default term-counter width
//   acc_w()    - accumulator width, 2N+G
package mac_pkg;

  localparam int MAC_N     = 4;
  localparam int MAC_G     = 4;
  localparam int MAC_CNT_W = 8;

  function automatic int acc_w(input int n, input int g);
    return 2 * n + g;
  endfunction

endpackage

// File: rtl/array_multiplier_Nbit.sv
// array_multiplier_Nbit: combinational unsigned N x N array multiplier.
//   a  in  N   multiplicand
//   b  in  N   multiplier
//   p  out 2N  product a*b
module array_multiplier_Nbit #(
  parameter int N = 4
) (
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic [2*N-1:0] p
);

  // part[i] is the running sum of the first i shifted partial-product rows
  logic [N:0][2*N-1:0] part;

  assign part[0] = '0;

  for (genvar i = 0; i < N; i++) begin : g_row
    logic [2*N-1:0] row;
    assign row         = {{N{1'b0}}, a & {N{b[i]}}} << i;
    assign part[i+1]   = part[i] + row;
  end

  assign p = part[N];

endmodule

// File: rtl/mac_accumulator.sv
// mac_accumulator: three-stage streaming multiply-accumulate.
//   clk, rst_n                    clock, async active-low reset
//   in_valid/in_ready             operand beat handshake
//   in_a, in_b (N), in_last       unsigned operands, packet terminator
//   out_valid/out_ready           result handshake
//   out_sum (ACC_W)               dot product modulo 2^ACC_W
//   out_ovf                       carry left ACC_W bits during the packet
//   out_terms (CNT_W)             beats in the packet, saturating
// S1 registers operands, S2 registers the product, S3 accumulates and
// holds the result. A single advance signal moves every stage together.
module mac_accumulator
  import mac_pkg::*;
#(
  parameter  int N     = MAC_N,
  parameter  int G     = MAC_G,
  parameter  int CNT_W = MAC_CNT_W,
  localparam int ACC_W = acc_w(N, G)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_a,
  input  logic [N-1:0]     in_b,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic             out_ovf,
  output logic [CNT_W-1:0] out_terms
);

  typedef struct packed {
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         last;
  } beat_t;

  typedef struct packed {
    logic [2*N-1:0] p;
    logic           last;
  } prod_t;

  logic             adv;
  logic [1:0]       vld_pipe;   // [0] = S1 valid, [1] = S2 valid
  beat_t            s1;
  prod_t            s2;
  logic [2*N-1:0]   p;

  logic [ACC_W-1:0] acc, acc_nxt;
  logic             ovf, ovf_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [ACC_W:0]   sum_ext;

  // Stall only when a result is held and not taken; depends on registered
  // out_valid, never on in_valid.
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  array_multiplier_Nbit #(.N(N)) u_mult (
    .a (s1.a),
    .b (s1.b),
    .p (p)
  );

  always_comb begin
    sum_ext = {1'b0, acc} + (ACC_W + 1)'(s2.p);
    acc_nxt = sum_ext[ACC_W-1:0];
    ovf_nxt = ovf | sum_ext[ACC_W];
    cnt_nxt = (cnt == '1) ? cnt : cnt + 1'b1;
  end

  // S1/S2: when not advancing everything holds, so stalled beats survive.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      s1       <= '0;
      s2       <= '0;
    end else if (adv) begin
      vld_pipe <= {vld_pipe[0], in_valid};
      s1       <= '{a: in_a, b: in_b, last: in_last};
      s2       <= '{p: p, last: s1.last};
    end
  end

  // S3. Under adv a held result is either absent or being consumed, so
  // out_valid falls unless a new last beat lands in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc       <= '0;
      ovf       <= 1'b0;
      cnt       <= '0;
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_ovf   <= 1'b0;
      out_terms <= '0;
    end else if (adv) begin
      out_valid <= 1'b0;
      if (vld_pipe[1]) begin
        if (s2.last) begin
          out_sum   <= acc_nxt;
          out_ovf   <= ovf_nxt;
          out_terms <= cnt_nxt;
          out_valid <= 1'b1;
          acc       <= '0;
          ovf       <= 1'b0;
          cnt       <= '0;
        end else begin
          acc <= acc_nxt;
          ovf <= ovf_nxt;
          cnt <= cnt_nxt;
        end
      end
    end
  end

endmodule

// File: tb/tb_mac_accumulator.sv
module tb_mac_accumulator;
  localparam int N     = 4;
  localparam int CNT_W = 8;
  localparam int ACC_W = 12;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [N-1:0]     in_a = '0;
  logic [N-1:0]     in_b = '0;
  logic             in_last = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [ACC_W-1:0] out_sum;
  logic             out_ovf;
  logic [CNT_W-1:0] out_terms;

  mac_accumulator #(.N(4), .G(4), .CNT_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_ovf   (out_ovf),
    .out_terms (out_terms)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [ACC_W-1:0] sum;
    logic             ovf;
    logic [CNT_W-1:0] terms;
  } res_t;

  res_t exp_q[$];
  res_t mon_e;
  int   total = 0;
  int   bad = 0;
  int   delivered = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  task automatic push(input int sum, input int ovf, input int terms);
    exp_q.push_back('{sum: ACC_W'(sum), ovf: 1'(ovf), terms: CNT_W'(terms)});
  endtask

  // Scoreboard monitor: a result transfers on the edge following a
  // negedge that sees out_valid && out_ready.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      delivered++;
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_result: got sum=%0d with no expected entry", out_sum);
      end else begin
        mon_e = exp_q.pop_front();
        check("out_sum", 32'(out_sum), 32'(mon_e.sum));
        check("out_ovf", 32'(out_ovf), 32'(mon_e.ovf));
        check("out_terms", 32'(out_terms), 32'(mon_e.terms));
      end
    end
  end

  // Drive a beat from posedge+1; returns at posedge+1 after acceptance.
  task automatic send(input int a, input int b, input bit last);
    int n;
    in_a = N'(a); in_b = N'(b); in_last = last; in_valid = 1'b1;
    n = 0;
    forever begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk); #1;
        break;
      end
      n++;
      if (n > 50) begin
        total++; bad++;
        $display("FAIL send_timeout: in_ready stuck 0 expected 1");
        break;
      end
    end
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_in_ready"},  32'(in_ready), 1);
    check({tag, "_out_valid"}, 32'(out_valid), 0);
    check({tag, "_out_sum"},   32'(out_sum), 0);
    check({tag, "_out_ovf"},   32'(out_ovf), 0);
    check({tag, "_out_terms"}, 32'(out_terms), 0);
  endtask

  logic [7:0] pat;
  int         d0;

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_vals("rst");
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(1);

    // Single beat, latency
    push(15, 0, 1);
    send(3, 5, 1);
    @(negedge clk); check("lat_edge1", 32'(out_valid), 0);
    @(negedge clk); check("lat_edge2", 32'(out_valid), 0);
    @(negedge clk); check("lat_edge3", 32'(out_valid), 1);
    idle(3);

    // Four beats of 15x15
    push(900, 0, 4);
    for (int i = 0; i < 4; i++) send(15, 15, i == 3);
    idle(4);

    // Nineteen beats of 15x15 wrap past 4096
    push(179, 1, 19);
    for (int i = 0; i < 19; i++) send(15, 15, i == 18);
    push(1, 0, 1);
    send(1, 1, 1);
    idle(4);

    // Term counter saturation: 260 beats of 1x1
    push(260, 0, 255);
    for (int i = 0; i < 260; i++) send(1, 1, i == 259);
    idle(4);

    // Stall with out_ready low for 5 cycles
    out_ready = 1'b0;
    push(30, 0, 1);
    push(81, 0, 1);
    d0 = delivered;
    send(10, 3, 1);
    send(9, 9, 1);
    @(negedge clk);
    check("stall_in_ready_pre", 32'(in_ready), 1);
    @(negedge clk);
    check("stall_out_valid", 32'(out_valid), 1);
    check("stall_in_ready_drop", 32'(in_ready), 0);
    check("stall_sum_a", 32'(out_sum), 30);
    @(negedge clk);
    check("stall_in_ready_hold", 32'(in_ready), 0);
    check("stall_sum_b", 32'(out_sum), 30);
    @(posedge clk); #1;
    out_ready = 1'b1;
    idle(4);
    check("stall_delivered", 32'(delivered - d0), 2);
    check("stall_queue_empty", 32'(exp_q.size()), 0);

    // Reset mid-packet discards partial sum
    push(0, 0, 1);
    send(9, 9, 0);
    send(9, 9, 0);
    rst_n = 1'b0;
    @(negedge clk);
    check_reset_vals("midrst");
    @(posedge clk); #1;
    rst_n = 1'b1;
    send(0, 15, 1);
    idle(4);

    // Back-to-back single-beat packets
    push(1, 0, 1); push(4, 0, 1); push(9, 0, 1); push(16, 0, 1);
    fork
      begin
        for (int i = 1; i <= 4; i++) send(i, i, 1'b1);
      end
      begin
        pat = '0;
        for (int i = 0; i < 8; i++) begin
          @(negedge clk);
          pat[i] = out_valid;
        end
      end
    join
    check("b2b_valid_pattern", 32'(pat), 32'h78);

    // Drain with a bounded wait
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
    check("final_queue_empty", 32'(exp_q.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
